// File: rtl/inst_enc_pkg.sv
// Shared types and constants for the instruction encoder: request formats,
// RV32I opcodes, error codes and the control FSM state encoding.
package inst_enc_pkg;

  typedef enum logic [2:0] {
    FMT_LOAD   = 3'd0,
    FMT_ALUI   = 3'd1,
    FMT_LUI    = 3'd2,
    FMT_STORE  = 3'd3,
    FMT_BRANCH = 3'd4
  } fmt_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_FMT   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_ENC  = 3'd2,
    S_WR   = 3'd3,
    S_FULL = 3'd4
  } state_t;

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I field packing plus immediate range/alignment checks.
// result_o = {word, err_code}; err_code is ERR_NONE when the word is legal.
module inst_pack
  import inst_enc_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [33:0] result_o
);

  logic        s12_ok;
  logic        u12_ok;
  logic        u5_ok;
  logic        b13_ok;
  logic [31:0] word;
  logic [1:0]  code;

  // A value fits an N-bit signed field when every bit from N-1 upward matches.
  assign s12_ok = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
  assign u12_ok = (imm_i[31:12] == '0);
  assign u5_ok  = (imm_i[31:5] == '0);
  // 4095 is representable in 13 bits but lies outside the branch range, so it
  // reports as a range error rather than an alignment error.
  assign b13_ok = ((imm_i[31:12] == '0) || (imm_i[31:12] == '1)) &&
                  (imm_i != 32'h0000_0fff);

  always_comb begin
    word = '0;
    code = ERR_NONE;
    case (fmt_t'(fmt_i))
      FMT_LOAD: begin
        word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
        if (funct3_i == 3'b100) code = u12_ok ? ERR_NONE : ERR_RANGE;
        else                    code = s12_ok ? ERR_NONE : ERR_RANGE;
      end
      FMT_ALUI: begin
        if ((funct3_i == 3'b000) || (funct3_i == 3'b010)) begin
          word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_ALUI};
          code = s12_ok ? ERR_NONE : ERR_RANGE;
        end else begin
          word = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, OP_ALUI};
          code = u5_ok ? ERR_NONE : ERR_RANGE;
        end
      end
      FMT_LUI: begin
        word = {imm_i[31:12], rd_i, OP_LUI};
        code = (imm_i[11:0] == '0) ? ERR_NONE : ERR_ALIGN;
      end
      FMT_STORE: begin
        word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
        code = s12_ok ? ERR_NONE : ERR_RANGE;
      end
      FMT_BRANCH: begin
        word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                imm_i[4:1], imm_i[11], OP_BRANCH};
        if (!b13_ok)      code = ERR_RANGE;
        else if (imm_i[0]) code = ERR_ALIGN;
        else               code = ERR_NONE;
      end
      default: code = ERR_FMT;
    endcase
  end

  assign result_o = {word, code};

endmodule

// File: rtl/inst_encoder.sv
// Instruction loader: accepts decoded fields over valid/ready, encodes them
// and writes legal words to consecutive instruction-memory addresses.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_fmt,
  input  logic [2:0]        req_funct3,
  input  logic [6:0]        req_funct7,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [2:0]        dbg_state
);

  // Handshake: a request transfers on the rising edge where req_valid and
  // req_ready are both high; req_ready depends only on state and stop, never
  // on req_valid, and a stop in the same cycle always blocks the transfer.

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic              full_q;
  logic              err_q;
  logic [1:0]        err_code_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        fmt_q;
  logic [2:0]        funct3_q;
  logic [6:0]        funct7_q;
  logic [4:0]        rd_q;
  logic [4:0]        rs1_q;
  logic [4:0]        rs2_q;
  logic [31:0]       imm_q;
  logic [33:0]       pack_result;
  logic [31:0]       pack_word;
  logic [1:0]        pack_err;

  inst_pack u_pack (
    .fmt_i    (fmt_q),
    .funct3_i (funct3_q),
    .funct7_i (funct7_q),
    .rd_i     (rd_q),
    .rs1_i    (rs1_q),
    .rs2_i    (rs2_q),
    .imm_i    (imm_q),
    .result_o (pack_result)
  );

  assign pack_word = pack_result[33:2];
  assign pack_err  = pack_result[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      fmt_q      <= '0;
      funct3_q   <= '0;
      funct7_q   <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ptr_q      <= start_addr;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_q <= S_IDLE;
          end else if (req_valid) begin
            fmt_q    <= req_fmt;
            funct3_q <= req_funct3;
            funct7_q <= req_funct7;
            rd_q     <= req_rd;
            rs1_q    <= req_rs1;
            rs2_q    <= req_rs2;
            imm_q    <= req_imm;
            state_q  <= S_ENC;
          end
        end
        S_ENC: begin
          if (pack_err != ERR_NONE) begin
            // Only the first error of a session is recorded in err_code.
            err_q <= 1'b1;
            if (err_code_q == ERR_NONE) err_code_q <= pack_err;
            state_q <= S_RUN;
          end else begin
            we_q    <= 1'b1;
            addr_q  <= ptr_q;
            wdata_q <= pack_word;
            state_q <= S_WR;
          end
        end
        S_WR: begin
          ptr_q <= ptr_q + ADDR_W'(1);
          cnt_q <= cnt_q + (ADDR_W + 1)'(1);
          if (ptr_q == '1) begin
            full_q  <= 1'b1;
            state_q <= S_FULL;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_FULL: begin
          if (stop) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_RUN) && !stop;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = cnt_q;
  assign full       = full_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign dbg_state  = state_q;

endmodule
